// File: rtl/asip_pkg.sv
// Shared definitions for the vector ASIP pipeline stages.
package asip_pkg;
    // The encoding is {skid_valid, main_valid}, so the valid flops are the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } pipe_state_t;

    localparam int PIPE_DEPTH = 2;
endpackage

// File: rtl/pipe_skid_reg_if.sv
// valid/ready/data handshake bundle. The master drives a word and the slave accepts it.
interface pipe_skid_reg_if #(parameter int N = 8);
    logic         valid;
    logic         ready;
    logic [N-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg_dreg.sv
// N-bit data register with a load enable and an asynchronous active-high reset.
module pipe_skid_reg_dreg #(parameter int N = 8) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     q <= '0;
        else if (load) q <= d;
    end
endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage with registered outputs. A main register feeds the consumer,
// and a skid register absorbs the single beat that arrives while the consumer stalls.
module pipe_skid_reg
    import asip_pkg::*;
#(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    pipe_skid_reg_if.slave    in_bus,
    pipe_skid_reg_if.master   out_bus
);
    logic         main_valid, skid_valid;
    logic [N-1:0] main_data, skid_data, main_d;
    logic         main_load, skid_load, main_from_skid;
    logic         in_fire, out_fire;
    logic [1:0]   state;

    assign state         = {skid_valid, main_valid};
    assign in_bus.ready  = !skid_valid;   // comes only from the flop, so out_ready cannot reach it combinationally
    assign out_bus.valid = main_valid;
    assign out_bus.data  = main_data;
    assign in_fire       = in_bus.valid & !skid_valid;
    assign out_fire      = main_valid & out_bus.ready;

    always_comb begin
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (!flush) begin
            case (state)
                EMPTY: main_load = in_fire;
                BUSY: begin
                    main_load = in_fire & out_fire;
                    skid_load = in_fire & !out_fire;
                end
                FULL: begin
                    main_load      = out_fire;
                    main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_data : in_bus.data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (in_fire) main_valid <= 1'b1;
                BUSY: begin
                    if (in_fire && !out_fire)      skid_valid <= 1'b1;
                    else if (!in_fire && out_fire) main_valid <= 1'b0;
                end
                FULL: if (out_fire) skid_valid <= 1'b0;
                default: begin
                    // 10 is unreachable; if it is ever entered, recover to EMPTY
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end

    pipe_skid_reg_dreg #(.N(N)) u_main (
        .clk(clk), .reset(reset), .load(main_load), .d(main_d), .q(main_data)
    );

    pipe_skid_reg_dreg #(.N(N)) u_skid (
        .clk(clk), .reset(reset), .load(skid_load), .d(in_bus.data), .q(skid_data)
    );
endmodule
